// File: rtl/mmio_port_bank_if.sv
// rtl/mmio_port_bank_if.sv - load/store bus and TX drain stream bundle for mmio_port_bank
interface mmio_port_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output we, re, addr, wdata, tx_ready,
    input  rdata, tx_data, tx_valid
  );

  modport slave (
    input  we, re, addr, wdata, tx_ready,
    output rdata, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - channel registers, TX FIFO, sticky overflow irq and cycle counter
module mmio_port_bank #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                     clk_t,
  input  logic                     rst_t,
  mmio_port_bank_if.slave          bus,
  output logic [NUM_CH*DATA_W-1:0] io_out,
  output logic                     irq
);
  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] OFF_TXD  = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] OFF_CYC  = ADDR_W'(NUM_CH + 2);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] ch_q [NUM_CH];
  logic [DATA_W-1:0] ch_d [NUM_CH];
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] cyc_q, cyc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W:0]   diff;
  logic [ADDR_W-1:0] off;
  logic              hit, wr_hit, full, pop, push_req, push_ok, ovf_clr;
  logic [DATA_W-1:0] stat, rd_mux;

  // The extra borrow bit flags addresses below BASE_ADDR as misses.
  assign diff     = {1'b0, bus.addr} - BASE_EXT;
  assign off      = diff[ADDR_W-1:0];
  assign hit      = !diff[ADDR_W] && (off <= OFF_CYC);
  assign wr_hit   = bus.we && hit;
  assign full     = (count_q == FULL_CNT);
  assign pop      = bus.tx_valid && bus.tx_ready;
  assign push_req = wr_hit && (off == OFF_TXD);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_clr  = wr_hit && (off == OFF_STAT) && bus.wdata[2];

  always_comb begin
    stat       = '0;
    stat[0]    = (count_q == '0);
    stat[1]    = full;
    stat[2]    = ovf_q;
    stat[15:8] = 8'(count_q);

    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (off == ADDR_W'(k)) rd_mux = ch_q[k];
      ch_d[k] = (wr_hit && off == ADDR_W'(k)) ? bus.wdata : ch_q[k];
    end
    if (off == OFF_STAT) rd_mux = stat;
    if (off == OFF_CYC)  rd_mux = cyc_q;
    if (!hit)            rd_mux = '0;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // A rejected push wins over a clear landing on the same edge.
    ovf_d   = (push_req && !push_ok) || (ovf_q && !ovf_clr);
    cyc_d   = (wr_hit && off == OFF_CYC) ? bus.wdata : cyc_q + DATA_W'(1);
    rdata_d = bus.re ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
      rdata_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= ch_d[k];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk_t) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.wdata;
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) io_out[k*DATA_W +: DATA_W] = ch_q[k];
  end

  assign bus.rdata    = rdata_q;
  assign bus.tx_valid = (count_q != '0);
  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign irq          = ovf_q;
endmodule
